// File: rtl/pipe_game_pkg.sv
// rtl/pipe_game_pkg.sv - shared pipe game types, state encoding and default parameters
package pipe_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PICK  = 2'd2,
        ST_ISSUE = 2'd3
    } spawn_state_t;

    localparam int         NUM_SLOTS         = 3;
    localparam logic [9:0] SCREEN_CENTER_Y   = 10'd240;

    localparam int         DEF_BASE_INTERVAL = 120;
    localparam int         DEF_MIN_INTERVAL  = 40;
    localparam int         DEF_INTERVAL_STEP = 4;
    localparam int         DEF_Y_OFFSET      = 112;
    localparam logic [9:0] DEF_LFSR_SEED     = 10'h2A5;

endpackage

// File: rtl/pipe_lfsr10.sv
// rtl/pipe_lfsr10.sv - 10-bit Fibonacci LFSR, polynomial x^10+x^7+1
module pipe_lfsr10 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] seed,
    input  logic       enable,
    output logic [9:0] lfsr
);

    // A non-zero seed keeps the register out of the all-zero lock-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= seed;
        end else if (enable) begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

endmodule

// File: rtl/pipe_spawn_scheduler.sv
// rtl/pipe_spawn_scheduler.sv - round-robin pipe spawn scheduler; PIPE_SPAWN_RANDOM_EN enables random gap Y
module pipe_spawn_scheduler
    import pipe_game_pkg::*;
#(
    parameter int         BASE_INTERVAL = DEF_BASE_INTERVAL,
    parameter int         MIN_INTERVAL  = DEF_MIN_INTERVAL,
    parameter int         INTERVAL_STEP = DEF_INTERVAL_STEP,
    parameter int         Y_OFFSET      = DEF_Y_OFFSET,
    parameter logic [9:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic       animationCLOCK,
    input  logic       resetN,
    input  logic       gameRunning,
    input  logic [9:0] score,
    input  logic [2:0] slotBusy,
    input  logic       endOfMapPipe,
    output logic [2:0] spawnReq,
    output logic [9:0] spawnY,
    output logic [9:0] spawnScore,
    output logic [9:0] spawnCount,
    output logic [9:0] pipesPassed
);

    spawn_state_t state, state_nx;
    logic [15:0]  counter;
    logic [15:0]  step_product;
    logic [15:0]  interval;
    logic [1:0]   last_slot;
    logic [1:0]   chosen;
    logic         pick_ok;
    logic [1:0]   pick_slot;
    logic [9:0]   gap_y;
    int           cand;

    assign step_product = 16'(score) * 16'(INTERVAL_STEP);
    assign interval     = (step_product >= 16'(BASE_INTERVAL - MIN_INTERVAL))
                        ? 16'(MIN_INTERVAL)
                        : 16'(BASE_INTERVAL) - step_product;

`ifdef PIPE_SPAWN_RANDOM_EN
    logic [9:0] lfsr_q;

    pipe_lfsr10 u_lfsr (
        .clk    (animationCLOCK),
        .rst_n  (resetN),
        .seed   (LFSR_SEED),
        .enable (1'b1),
        .lfsr   (lfsr_q)
    );

    assign gap_y = 10'(Y_OFFSET) + (lfsr_q & 10'h0FF);
`else
    assign gap_y = SCREEN_CENTER_Y;
`endif

    // Search starts one past the last served slot, so every slot gets a turn.
    always_comb begin
        pick_ok   = 1'b0;
        pick_slot = last_slot;
        cand      = 0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            cand = (int'(last_slot) + k) % NUM_SLOTS;
            if (!pick_ok && !slotBusy[cand]) begin
                pick_ok   = 1'b1;
                pick_slot = 2'(cand);
            end
        end
    end

    always_ff @(posedge animationCLOCK or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!gameRunning) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nx = ST_WAIT;
                ST_WAIT:  if (counter == 16'd0) state_nx = ST_PICK;
                ST_PICK:  if (pick_ok) state_nx = ST_ISSUE;
                ST_ISSUE: state_nx = ST_WAIT;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        spawnReq = 3'b000;
        if (state == ST_ISSUE) begin
            spawnReq = 3'b001 << chosen;
        end
    end

    always_ff @(posedge animationCLOCK or negedge resetN) begin
        if (!resetN) begin
            counter     <= 16'd0;
            last_slot   <= 2'd2;
            chosen      <= 2'd0;
            spawnY      <= 10'd0;
            spawnScore  <= 10'd0;
            spawnCount  <= 10'd0;
            pipesPassed <= 10'd0;
        end else if (state == ST_IDLE) begin
            if (gameRunning) begin
                counter     <= interval;
                spawnCount  <= 10'd0;
                pipesPassed <= endOfMapPipe ? 10'd1 : 10'd0;
            end
        end else begin
            if (endOfMapPipe && pipesPassed != 10'h3FF) begin
                pipesPassed <= pipesPassed + 10'd1;
            end
            // Dropping gameRunning aborts the cycle: no count, no slot rotation.
            if (gameRunning) begin
                case (state)
                    ST_WAIT: begin
                        if (counter != 16'd0) counter <= counter - 16'd1;
                    end
                    ST_PICK: begin
                        if (pick_ok) begin
                            chosen     <= pick_slot;
                            spawnY     <= gap_y;
                            spawnScore <= score;
                        end
                    end
                    ST_ISSUE: begin
                        spawnCount <= spawnCount + 10'd1;
                        last_slot  <= chosen;
                        counter    <= interval;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_spawn_scheduler.sv
// tb/tb_pipe_spawn_scheduler.sv - self-checking bench for pipe_spawn_scheduler
module tb_pipe_spawn_scheduler;

    logic       clk          = 1'b0;
    logic       resetN       = 1'b0;
    logic       gameRunning  = 1'b0;
    logic [9:0] score        = 10'd0;
    logic [2:0] slotBusy     = 3'b000;
    logic       endOfMapPipe = 1'b0;
    logic [2:0] spawnReq;
    logic [9:0] spawnY;
    logic [9:0] spawnScore;
    logic [9:0] spawnCount;
    logic [9:0] pipesPassed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_spawn_scheduler dut (
        .animationCLOCK (clk),
        .resetN         (resetN),
        .gameRunning    (gameRunning),
        .score          (score),
        .slotBusy       (slotBusy),
        .endOfMapPipe   (endOfMapPipe),
        .spawnReq       (spawnReq),
        .spawnY         (spawnY),
        .spawnScore     (spawnScore),
        .spawnCount     (spawnCount),
        .pipesPassed    (pipesPassed)
    );

    typedef struct {
        int sc;
        int first_edge;
        int period;
    } vec_t;

    vec_t tbl[7];

    // Reference model state: spawn timeline expressed as edges remaining until a pick.
    bit       m_active;
    int       m_wait;
    int       m_cnt;
    int       m_pp;
    int       m_last;
    int       m_chosen;
    int       m_score;
    logic [2:0] m_req;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_y(input string name);
`ifdef PIPE_SPAWN_RANDOM_EN
        checks++;
        if (spawnY < 10'd112 || spawnY > 10'd367) begin
            errors++;
            $display("FAIL %s: got %0d expected 112..367", name, spawnY);
        end
`else
        check(name, int'(spawnY), 240);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int interval_of(input int sc);
        int p;
        p = (sc * 4) & 32'hFFFF;
        return (p >= 80) ? 40 : 120 - p;
    endfunction

    task automatic do_reset();
        gameRunning  = 1'b0;
        endOfMapPipe = 1'b0;
        slotBusy     = 3'b000;
        resetN       = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_wait   = 0;
        m_cnt    = 0;
        m_pp     = 0;
        m_last   = 2;
        m_chosen = 0;
        m_score  = 0;
        m_req    = 3'b000;
    endtask

    task automatic model_step(input logic gr, input logic [2:0] busy, input logic eop, input int sc);
        bit found;
        int s;
        if (!m_active) begin
            m_req = 3'b000;
            if (gr) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_pp     = eop ? 1 : 0;
                m_wait   = interval_of(sc) + 1;
            end
        end else begin
            if (eop && m_pp < 1023) m_pp++;
            if (!gr) begin
                m_active = 1'b0;
                m_req    = 3'b000;
            end else if (m_req != 3'b000) begin
                m_cnt  = (m_cnt + 1) % 1024;
                m_last = m_chosen;
                m_req  = 3'b000;
                m_wait = interval_of(sc) + 1;
            end else if (m_wait > 0) begin
                m_wait--;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    s = (m_last + k) % 3;
                    if (!found && !busy[s]) begin
                        found    = 1'b1;
                        m_chosen = s;
                        m_score  = sc;
                        m_req    = 3'(1 << s);
                    end
                end
            end
        end
    endtask

    initial begin
        int e;
        int t0;
        int seen;
        int sc;

        tbl[0] = '{0,    122, 123};
        tbl[1] = '{10,   82,  83};
        tbl[2] = '{20,   42,  43};
        tbl[3] = '{500,  42,  43};
        tbl[4] = '{5,    102, 103};
        tbl[5] = '{19,   46,  47};
        tbl[6] = '{1023, 42,  43};

        // Reset state
        resetN = 1'b0;
        step();
        check("rst_req",    int'(spawnReq),    0);
        check("rst_y",      int'(spawnY),      0);
        check("rst_score",  int'(spawnScore),  0);
        check("rst_count",  int'(spawnCount),  0);
        check("rst_passed", int'(pipesPassed), 0);

        // Interval table: first spawn edge and steady-state period
        for (int i = 0; i < 7; i++) begin
            do_reset();
            score       = 10'(tbl[i].sc);
            gameRunning = 1'b1;
            step();
            e = 0;
            while (spawnReq == 3'b000 && e < 400) begin
                step();
                e++;
            end
            check($sformatf("first_edge[%0d]", i), e, tbl[i].first_edge);
            check($sformatf("first_req[%0d]", i), int'(spawnReq), 1);
            check($sformatf("first_score[%0d]", i), int'(spawnScore), tbl[i].sc);
            check_y($sformatf("first_y[%0d]", i));
            t0 = e;
            step();
            e++;
            while (spawnReq == 3'b000 && e < t0 + 400) begin
                step();
                e++;
            end
            check($sformatf("period[%0d]", i), e - t0, tbl[i].period);
            check($sformatf("second_req[%0d]", i), int'(spawnReq), 2);
            check($sformatf("count_in_issue[%0d]", i), int'(spawnCount), 1);
            step();
            check($sformatf("count_after[%0d]", i), int'(spawnCount), 2);
        end

        // All slots busy: PICK holds with no timeout
        do_reset();
        score       = 10'd20;
        slotBusy    = 3'b111;
        gameRunning = 1'b1;
        step();
        endOfMapPipe = 1'b1;
        step();
        step();
        step();
        endOfMapPipe = 1'b0;
        seen = 0;
        for (int k = 0; k < 92; k++) begin
            step();
            if (spawnReq != 3'b000) seen++;
        end
        check("busy_no_spawn", seen, 0);
        check("busy_passed", int'(pipesPassed), 3);
        slotBusy = 3'b101;
        step();
        check("busy_release_req", int'(spawnReq), 2);

        // Abort in ISSUE, then restart clears counters
        gameRunning = 1'b0;
        step();
        check("abort_req", int'(spawnReq), 0);
        check("abort_count", int'(spawnCount), 0);
        check("abort_passed", int'(pipesPassed), 3);
        slotBusy     = 3'b000;
        gameRunning  = 1'b1;
        endOfMapPipe = 1'b1;
        step();
        endOfMapPipe = 1'b0;
        check("restart_passed", int'(pipesPassed), 1);
        check("restart_count", int'(spawnCount), 0);
        check("restart_req", int'(spawnReq), 0);
        e = 0;
        while (spawnReq == 3'b000 && e < 400) begin
            step();
            e++;
        end
        check("restart_edge", e, 42);
        check("restart_slot", int'(spawnReq), 1);
        step();
        step();
        step();

        // Asynchronous reset mid-WAIT
        #3;
        resetN = 1'b0;
        #1;
        check("async_req",    int'(spawnReq),    0);
        check("async_y",      int'(spawnY),      0);
        check("async_score",  int'(spawnScore),  0);
        check("async_count",  int'(spawnCount),  0);
        check("async_passed", int'(pipesPassed), 0);
        #2;
        resetN = 1'b1;
        step();
        check("post_reset_req", int'(spawnReq), 0);

        // pipesPassed saturation
        do_reset();
        score        = 10'd0;
        gameRunning  = 1'b1;
        endOfMapPipe = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            step();
            if (spawnReq != 3'b000) check_y("sat_y");
        end
        endOfMapPipe = 1'b0;
        check("sat_passed", int'(pipesPassed), 1023);
        check("sat_count", int'(spawnCount), 8);

        // Randomized run against the reference model
        for (int trial = 0; trial < 6; trial++) begin
            do_reset();
            model_reset();
            sc    = int'($urandom_range(0, 25));
            score = 10'(sc);
            for (int cyc = 0; cyc < 400; cyc++) begin
                gameRunning  = ($urandom_range(0, 99) < 97);
                slotBusy     = 3'($urandom_range(0, 7));
                endOfMapPipe = ($urandom_range(0, 3) == 0);
                step();
                model_step(gameRunning, slotBusy, endOfMapPipe, sc);
                check($sformatf("rnd_req[%0d.%0d]", trial, cyc), int'(spawnReq), int'(m_req));
                check($sformatf("rnd_count[%0d.%0d]", trial, cyc), int'(spawnCount), m_cnt);
                check($sformatf("rnd_passed[%0d.%0d]", trial, cyc), int'(pipesPassed), m_pp);
                if (m_req != 3'b000) begin
                    check($sformatf("rnd_score[%0d.%0d]", trial, cyc), int'(spawnScore), m_score);
                    check_y($sformatf("rnd_y[%0d.%0d]", trial, cyc));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
